capture_sequencer: RTL and testbench
====================================

// Module: capture_sequencer
// PURPOSE
//   Run-control FSM for the capture engine. Arms the engine, watches the
//   sampled port for a masked pattern/edge trigger, counts post-trigger BRAM
//   writes, then stops the engine and flags completion to the host regs.
//   Sits between the host register file and the capture engine's start/stop
//   control bits; monitors the engine's we/address outputs.
// PARAMETERS
//   CNT_W   19  width of post-trigger write counter and post_count
//   ADDR_W  18  width of BRAM write address observed/latched
// PORTS
//   clk         in   1       system clock
//   reset       in   1       async reset, active-high
//   arm         in   1       host pulse: begin a run (IDLE/DONE only)
//   abort       in   1       host pulse: cancel run from any state
//   trig_mask   in   8       1 = channel participates in trigger
//   trig_value  in   8       required level per masked channel
//   trig_edge   in   1       1 = fire only on first cycle of match
//   post_count  in   CNT_W   BRAM writes to keep after trigger
//   datain      in   8       raw port samples (asynchronous)
//   cap_we      in   1       capture engine BRAM write strobe
//   cap_addr    in   ADDR_W  capture engine BRAM address
//   cap_full    in   1       capture engine buffer-full indication
//   cap_start   out  1       1-cycle pulse -> engine control[0]
//   cap_stop    out  1       1-cycle pulse -> engine control[1]
//   busy        out  1       1 in START/WAIT_TRIG/POST/STOP
//   triggered   out  1       sticky: trigger fired this run
//   done        out  1       sticky: run finished (DONE state)
//   aborted     out  1       sticky: last run ended by abort
//   no_trig     out  1       sticky: buffer filled before trigger
//   trig_addr   out  ADDR_W  cap_addr latched on trigger cycle
//   state_o     out  3       current state encoding (status reg)
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0, sync regs 0.
//   datain passes a 2-flop synchroniser -> s; s_prev = s delayed 1 cycle.
//   match = ((s ^ trig_value) & trig_mask) == 0.
//   fire  = (trig_mask == 0) | (match & (~trig_edge | ~match_prev)).
//   States (state_o): IDLE=0 START=1 WAIT_TRIG=2 POST=3 STOP=4 DONE=5.
//   IDLE/DONE: arm -> START; clears triggered/done/aborted/no_trig,
//     post counter, trig_addr. Other inputs ignored.
//   START: cap_start=1 for this one cycle; next WAIT_TRIG. match_prev
//     forced 1 on entry to WAIT_TRIG, so a level already present does not
//     fire in edge mode.
//   WAIT_TRIG: fire -> POST, triggered<=1, trig_addr<=cap_addr.
//     cap_full (no fire same cycle) -> STOP, no_trig<=1.
//     fire and cap_full in same cycle: fire wins.
//   POST: each cap_we increments counter (CNT_W bits, no wrap: saturates).
//     Exit to STOP when counter == post_count or cap_full. post_count==0
//     exits on the first POST cycle. cap_we on the exit cycle is counted.
//   STOP: cap_stop=1 for this one cycle; next DONE (or IDLE if aborting).
//   DONE: done=1, busy=0; held until arm (new run) or abort (-> IDLE,
//     done cleared, aborted unchanged).
//   abort: highest priority. START/WAIT_TRIG/POST -> STOP, aborted<=1,
//     then IDLE (done stays 0). abort in STOP completes the stop, then IDLE.
//     abort in IDLE: no effect. arm and abort together: abort wins.
//   arm while busy: ignored. cap_start/cap_stop never both 1; each is
//     exactly 1 cycle per run. Reset mid-run drops outputs immediately;
//     the engine is not sent cap_stop (host must reset both blocks).
// TESTING
//   mask=0, arm -> cap_start at cycle+1, triggered at +2, post_count=0 ->
//     cap_stop next, done=1, trig_addr=cap_addr at trigger cycle.
//   mask=8'h01 val=8'h01 edge=1, datain[0] held 1 before arm -> no trigger;
//     drop then raise -> fire 3 cycles after rise (sync + compare).
//   post_count=5, 7 cap_we pulses after trigger -> cap_stop one cycle after
//     5th cap_we, counter==5, no further increment.
//   No trigger, assert cap_full in WAIT_TRIG -> no_trig=1, cap_stop once,
//     done=1, triggered=0.
//   abort in POST with arm same cycle -> cap_stop once, aborted=1, IDLE,
//     done=0; subsequent arm clears aborted and restarts.
//   reset asserted in POST -> all outputs 0 asynchronously, state_o=0.

Source files
------------

// File: rtl/capture_sequencer_if.sv
// -----------------------------------------------------------------------------
// capture_sequencer_if
//   Bundles the host-register and capture-engine signals seen by the capture
//   run-control sequencer. Signal names carry the i_/o_ prefix from the
//   sequencer's point of view.
//
//   Host side   : i_arm, i_abort, i_trig_mask, i_trig_value, i_trig_edge,
//                 i_post_count -> sequencer
//                 o_busy, o_triggered, o_done, o_aborted, o_no_trig,
//                 o_trig_addr, o_state <- sequencer
//   Engine side : i_datain (raw async samples), i_cap_we, i_cap_addr,
//                 i_cap_full -> sequencer
//                 o_cap_start, o_cap_stop <- sequencer
//
//   modport master : the host/engine side that drives the sequencer inputs
//   modport slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface capture_sequencer_if #(
  parameter int CNT_W  = 19,
  parameter int ADDR_W = 18
);
  logic              i_arm;
  logic              i_abort;
  logic [7:0]        i_trig_mask;
  logic [7:0]        i_trig_value;
  logic              i_trig_edge;
  logic [CNT_W-1:0]  i_post_count;
  logic [7:0]        i_datain;
  logic              i_cap_we;
  logic [ADDR_W-1:0] i_cap_addr;
  logic              i_cap_full;

  logic              o_cap_start;
  logic              o_cap_stop;
  logic              o_busy;
  logic              o_triggered;
  logic              o_done;
  logic              o_aborted;
  logic              o_no_trig;
  logic [ADDR_W-1:0] o_trig_addr;
  logic [2:0]        o_state;

  modport master (
    output i_arm, i_abort, i_trig_mask, i_trig_value, i_trig_edge,
           i_post_count, i_datain, i_cap_we, i_cap_addr, i_cap_full,
    input  o_cap_start, o_cap_stop, o_busy, o_triggered, o_done,
           o_aborted, o_no_trig, o_trig_addr, o_state
  );

  modport slave (
    input  i_arm, i_abort, i_trig_mask, i_trig_value, i_trig_edge,
           i_post_count, i_datain, i_cap_we, i_cap_addr, i_cap_full,
    output o_cap_start, o_cap_stop, o_busy, o_triggered, o_done,
           o_aborted, o_no_trig, o_trig_addr, o_state
  );
endinterface

// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
//   Run-control FSM for the capture engine. Arms the engine, waits for a
//   masked level/edge trigger on the synchronised sample port, counts the
//   post-trigger BRAM writes, then stops the engine and reports completion.
//
//   Ports
//     i_clk : system clock
//     i_rst : asynchronous reset, active-high
//     bus   : capture_sequencer_if.slave (host controls/status and engine
//             start/stop, write strobe, address and full indication)
//
//   State encoding on o_state: IDLE=0 START=1 WAIT_TRIG=2 POST=3 STOP=4 DONE=5
// -----------------------------------------------------------------------------
module capture_sequencer #(
  parameter int CNT_W  = 19,
  parameter int ADDR_W = 18
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  capture_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_STOP      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t            r_state;
  logic [7:0]        r_sync1;
  logic [7:0]        r_s;
  logic              r_match_prev;
  logic              r_aborting;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_cap_start;
  logic              r_cap_stop;
  logic              r_busy;
  logic              r_triggered;
  logic              r_done;
  logic              r_aborted;
  logic              r_no_trig;

  logic              w_match;
  logic              w_fire;
  logic              w_cnt_sat;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_post_exit;

  assign w_match = ((r_s ^ bus.i_trig_value) & bus.i_trig_mask) == 8'h00;

  // An empty mask fires unconditionally; edge mode needs the previous
  // cycle to have been a non-match.
  assign w_fire = (bus.i_trig_mask == 8'h00) |
                  (w_match & (~bus.i_trig_edge | ~r_match_prev));

  // The counter saturates instead of wrapping so a huge post_count can
  // never be skipped past.
  assign w_cnt_sat  = &r_cnt;
  assign w_cnt_next = (bus.i_cap_we && !w_cnt_sat) ? r_cnt + CNT_W'(1) : r_cnt;

  // Comparing both the current and the next count lets post_count==0 leave
  // on the first POST cycle even if a write lands in that same cycle.
  assign w_post_exit = (r_cnt == bus.i_post_count) |
                       (w_cnt_next == bus.i_post_count) |
                       bus.i_cap_full;

  // Two-flop synchroniser for the asynchronous sample port, plus the
  // previous-cycle match used for edge detection. match_prev is forced high
  // while in START so a level already present at arm time cannot look like
  // an edge on the first WAIT_TRIG cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1      <= 8'h00;
      r_s          <= 8'h00;
      r_match_prev <= 1'b0;
    end else begin
      r_sync1      <= bus.i_datain;
      r_s          <= r_sync1;
      r_match_prev <= (r_state == S_START) ? 1'b1 : w_match;
    end
  end

  // Main run-control FSM. All outputs are registered here; start/stop
  // pulses default low and are raised on the transition into START/STOP so
  // they are high for exactly the one cycle spent in that state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_aborting  <= 1'b0;
      r_cnt       <= '0;
      r_trig_addr <= '0;
      r_cap_start <= 1'b0;
      r_cap_stop  <= 1'b0;
      r_busy      <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_no_trig   <= 1'b0;
    end else begin
      r_cap_start <= 1'b0;
      r_cap_stop  <= 1'b0;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.i_abort) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else if (bus.i_arm) begin
            r_state     <= S_START;
            r_cap_start <= 1'b1;
            r_busy      <= 1'b1;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_no_trig   <= 1'b0;
            r_aborting  <= 1'b0;
            r_cnt       <= '0;
            r_trig_addr <= '0;
          end
        end

        S_START: begin
          if (bus.i_abort) begin
            r_state    <= S_STOP;
            r_cap_stop <= 1'b1;
            r_aborted  <= 1'b1;
            r_aborting <= 1'b1;
          end else begin
            r_state <= S_WAIT_TRIG;
          end
        end

        // Trigger beats buffer-full when both happen in the same cycle.
        S_WAIT_TRIG: begin
          if (bus.i_abort) begin
            r_state    <= S_STOP;
            r_cap_stop <= 1'b1;
            r_aborted  <= 1'b1;
            r_aborting <= 1'b1;
          end else if (w_fire) begin
            r_state     <= S_POST;
            r_triggered <= 1'b1;
            r_trig_addr <= bus.i_cap_addr;
          end else if (bus.i_cap_full) begin
            r_state    <= S_STOP;
            r_cap_stop <= 1'b1;
            r_no_trig  <= 1'b1;
          end
        end

        S_POST: begin
          if (bus.i_abort) begin
            r_state    <= S_STOP;
            r_cap_stop <= 1'b1;
            r_aborted  <= 1'b1;
            r_aborting <= 1'b1;
          end else begin
            r_cnt <= w_cnt_next;
            if (w_post_exit) begin
              r_state    <= S_STOP;
              r_cap_stop <= 1'b1;
            end
          end
        end

        // The stop pulse always completes; an abort seen here or earlier
        // sends the FSM back to IDLE instead of DONE.
        S_STOP: begin
          r_busy <= 1'b0;
          if (bus.i_abort || r_aborting) begin
            r_state    <= S_IDLE;
            r_aborted  <= 1'b1;
            r_aborting <= 1'b0;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_cap_start = r_cap_start;
  assign bus.o_cap_stop  = r_cap_stop;
  assign bus.o_busy      = r_busy;
  assign bus.o_triggered = r_triggered;
  assign bus.o_done      = r_done;
  assign bus.o_aborted   = r_aborted;
  assign bus.o_no_trig   = r_no_trig;
  assign bus.o_trig_addr = r_trig_addr;
  assign bus.o_state     = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// -----------------------------------------------------------------------------
// tb_capture_sequencer
//   Directed bench for capture_sequencer. A table of per-cycle rows walks
//   through several complete runs; hand-written sequences cover the edge
//   trigger timing and an asynchronous reset in the middle of a run.
//   Flags are compared as {start, stop, busy, triggered, done, aborted,
//   no_trig}.
// -----------------------------------------------------------------------------
module tb_capture_sequencer;
   localparam int CNT_W  = 19;
   localparam int ADDR_W = 18;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;

   capture_sequencer_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus();

   capture_sequencer #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              arm;
      logic              abort;
      logic [7:0]        mask;
      logic [7:0]        value;
      logic              edgeMode;
      logic [CNT_W-1:0]  post;
      logic [7:0]        datain;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic              full;
      logic [2:0]        expState;
      logic [6:0]        expFlags;
      logic [ADDR_W-1:0] expAddr;
   } vec_t;

   vec_t vecs[$];

   logic [7:0]       cfgMask;
   logic [7:0]       cfgValue;
   logic             cfgEdge;
   logic [CNT_W-1:0] cfgPost;
   logic [7:0]       cfgData;

   // Rows pick up whatever run configuration is current when they are added.
   task automatic addRow(input logic arm, input logic abort, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic full,
                         input logic [2:0] st, input logic [6:0] fl,
                         input logic [ADDR_W-1:0] ta);
      vec_t v;
      v.arm = arm; v.abort = abort; v.mask = cfgMask; v.value = cfgValue;
      v.edgeMode = cfgEdge; v.post = cfgPost; v.datain = cfgData;
      v.we = we; v.addr = addr; v.full = full;
      v.expState = st; v.expFlags = fl; v.expAddr = ta;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.i_arm        = v.arm;
      bus.i_abort      = v.abort;
      bus.i_trig_mask  = v.mask;
      bus.i_trig_value = v.value;
      bus.i_trig_edge  = v.edgeMode;
      bus.i_post_count = v.post;
      bus.i_datain     = v.datain;
      bus.i_cap_we     = v.we;
      bus.i_cap_addr   = v.addr;
      bus.i_cap_full   = v.full;
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] flagsNow();
      return {bus.o_cap_start, bus.o_cap_stop, bus.o_busy, bus.o_triggered,
              bus.o_done, bus.o_aborted, bus.o_no_trig};
   endfunction

   task automatic compareOne(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [2:0] expState,
                              input logic [6:0] expFlags,
                              input logic [ADDR_W-1:0] expAddr);
      compareOne({name, ".state"}, 32'(bus.o_state), 32'(expState));
      compareOne({name, ".flags"}, 32'(flagsNow()), 32'(expFlags));
      compareOne({name, ".trig_addr"}, 32'(bus.o_trig_addr), 32'(expAddr));
   endtask

   task automatic buildTable();
      // Run A: empty mask fires at once, post_count 0
      cfgMask = 8'h00; cfgValue = 8'h00; cfgEdge = 1'b0; cfgPost = 19'd0; cfgData = 8'h00;
      addRow(1, 0, 0, 18'h3FFFF, 0, 3'd1, 7'b1010000, 18'h00000);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd2, 7'b0010000, 18'h00000);
      addRow(0, 0, 0, 18'h00123, 0, 3'd3, 7'b0011000, 18'h00123);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd4, 7'b0111000, 18'h00123);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd5, 7'b0001100, 18'h00123);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd5, 7'b0001100, 18'h00123);
      // Run B: post_count 5 with 7 write pulses, re-armed from DONE
      cfgPost = 19'd5;
      addRow(1, 0, 0, 18'h3FFFF, 0, 3'd1, 7'b1010000, 18'h00000);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd2, 7'b0010000, 18'h00000);
      addRow(0, 0, 0, 18'h000AB, 0, 3'd3, 7'b0011000, 18'h000AB);
      addRow(0, 0, 1, 18'h3FFFF, 0, 3'd3, 7'b0011000, 18'h000AB);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd3, 7'b0011000, 18'h000AB);
      addRow(0, 0, 1, 18'h3FFFF, 0, 3'd3, 7'b0011000, 18'h000AB);
      addRow(0, 0, 1, 18'h3FFFF, 0, 3'd3, 7'b0011000, 18'h000AB);
      addRow(0, 0, 1, 18'h3FFFF, 0, 3'd3, 7'b0011000, 18'h000AB);
      addRow(0, 0, 1, 18'h3FFFF, 0, 3'd4, 7'b0111000, 18'h000AB);
      addRow(0, 0, 1, 18'h3FFFF, 0, 3'd5, 7'b0001100, 18'h000AB);
      addRow(0, 0, 1, 18'h3FFFF, 0, 3'd5, 7'b0001100, 18'h000AB);
      // Run C: pattern never matches, buffer fills while waiting
      cfgMask = 8'hFF; cfgValue = 8'hA5;
      addRow(1, 0, 0, 18'h3FFFF, 0, 3'd1, 7'b1010000, 18'h00000);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd2, 7'b0010000, 18'h00000);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd2, 7'b0010000, 18'h00000);
      addRow(0, 0, 0, 18'h3FFFF, 1, 3'd4, 7'b0110001, 18'h00000);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd5, 7'b0000101, 18'h00000);
      // Run D: abort+arm in POST, then abort in START, abort in IDLE
      cfgMask = 8'h00; cfgValue = 8'h00;
      addRow(1, 0, 0, 18'h3FFFF, 0, 3'd1, 7'b1010000, 18'h00000);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd2, 7'b0010000, 18'h00000);
      addRow(0, 0, 0, 18'h00055, 0, 3'd3, 7'b0011000, 18'h00055);
      addRow(0, 0, 1, 18'h3FFFF, 0, 3'd3, 7'b0011000, 18'h00055);
      addRow(1, 1, 0, 18'h3FFFF, 0, 3'd4, 7'b0111010, 18'h00055);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd0, 7'b0001010, 18'h00055);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd0, 7'b0001010, 18'h00055);
      addRow(1, 0, 0, 18'h3FFFF, 0, 3'd1, 7'b1010000, 18'h00000);
      addRow(0, 1, 0, 18'h3FFFF, 0, 3'd4, 7'b0110010, 18'h00000);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd0, 7'b0000010, 18'h00000);
      addRow(0, 1, 0, 18'h3FFFF, 0, 3'd0, 7'b0000010, 18'h00000);
      addRow(1, 1, 0, 18'h3FFFF, 0, 3'd0, 7'b0000010, 18'h00000);
      // Run E: arm while busy ignored, fire beats full, abort from DONE
      cfgPost = 19'd0;
      addRow(1, 0, 0, 18'h3FFFF, 0, 3'd1, 7'b1010000, 18'h00000);
      addRow(1, 0, 0, 18'h3FFFF, 0, 3'd2, 7'b0010000, 18'h00000);
      addRow(0, 0, 0, 18'h00001, 1, 3'd3, 7'b0011000, 18'h00001);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd4, 7'b0111000, 18'h00001);
      addRow(0, 0, 0, 18'h3FFFF, 0, 3'd5, 7'b0001100, 18'h00001);
      addRow(0, 1, 0, 18'h3FFFF, 0, 3'd0, 7'b0001000, 18'h00001);
   endtask

   initial begin
      bus.i_arm = 1'b0; bus.i_abort = 1'b0; bus.i_trig_mask = 8'h00;
      bus.i_trig_value = 8'h00; bus.i_trig_edge = 1'b0; bus.i_post_count = '0;
      bus.i_datain = 8'h00; bus.i_cap_we = 1'b0; bus.i_cap_addr = '0;
      bus.i_cap_full = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", 3'd0, 7'b0000000, 18'h00000);
      rst = 1'b0;
      stepClk();
      checkOutput("idle", 3'd0, 7'b0000000, 18'h00000);

      buildTable();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         stepClk();
         checkOutput($sformatf("row%0d", i), vecs[i].expState,
                     vecs[i].expFlags, vecs[i].expAddr);
      end

      // Edge trigger: level held before arm must not fire; a fresh rise
      // fires after two synchroniser flops plus the compare cycle.
      bus.i_arm = 1'b0; bus.i_abort = 1'b0; bus.i_trig_mask = 8'h01;
      bus.i_trig_value = 8'h01; bus.i_trig_edge = 1'b1; bus.i_post_count = 19'd0;
      bus.i_datain = 8'h01; bus.i_cap_we = 1'b0; bus.i_cap_addr = 18'h2A5A5;
      bus.i_cap_full = 1'b0;
      repeat (3) stepClk();
      checkOutput("edge_pre", 3'd0, 7'b0001000, 18'h00001);
      bus.i_arm = 1'b1;
      stepClk();
      bus.i_arm = 1'b0;
      checkOutput("edge_start", 3'd1, 7'b1010000, 18'h00000);
      stepClk();
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("edge_held%0d", k), 3'd2, 7'b0010000, 18'h00000);
         stepClk();
      end
      bus.i_datain = 8'h00;
      for (int k = 0; k < 3; k++) begin
         stepClk();
         checkOutput($sformatf("edge_low%0d", k), 3'd2, 7'b0010000, 18'h00000);
      end
      bus.i_datain = 8'h01;
      stepClk();
      checkOutput("edge_rise1", 3'd2, 7'b0010000, 18'h00000);
      stepClk();
      checkOutput("edge_rise2", 3'd2, 7'b0010000, 18'h00000);
      stepClk();
      checkOutput("edge_fire", 3'd3, 7'b0011000, 18'h2A5A5);
      stepClk();
      checkOutput("edge_stop", 3'd4, 7'b0111000, 18'h2A5A5);
      stepClk();
      checkOutput("edge_done", 3'd5, 7'b0001100, 18'h2A5A5);

      // Asynchronous reset in the middle of POST clears everything at once.
      bus.i_trig_mask = 8'h00; bus.i_post_count = 19'd5; bus.i_cap_addr = 18'h01234;
      bus.i_arm = 1'b1;
      stepClk();
      bus.i_arm = 1'b0;
      stepClk();
      stepClk();
      checkOutput("rst_post", 3'd3, 7'b0011000, 18'h01234);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async", 3'd0, 7'b0000000, 18'h00000);
      #3;
      rst = 1'b0;
      stepClk();
      checkOutput("rst_after", 3'd0, 7'b0000000, 18'h00000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
